// File: rtl/psum_accumulator.sv
// Accumulates a window of signed column partial sums, then shifts, clamps and
// presents one output activation over a valid/ready handshake.
module psum_accumulator #(
  parameter int DATA_WIDTH       = 8,
  parameter int COLUMN_OUT_WIDTH = 19,
  parameter int LEN_WIDTH        = 4,
  parameter int ACC_WIDTH        = COLUMN_OUT_WIDTH + LEN_WIDTH + 1
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_start,
  input  logic [LEN_WIDTH-1:0]               i_len,
  input  logic [3:0]                         i_shift,
  input  logic                               i_relu,
  input  logic                               i_psum_valid,
  input  logic signed [COLUMN_OUT_WIDTH-1:0] i_psum_column,
  output logic                               o_psum_ready,
  output logic                               o_data_valid,
  output logic [DATA_WIDTH-1:0]              o_data,
  input  logic                               i_data_ready,
  output logic                               o_busy,
  output logic                               o_done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] OUT   = 2'd2;

  // One extra bit so a zero length field can encode a full 2^LEN_WIDTH window.
  localparam int CNT_WIDTH = LEN_WIDTH + 1;

  localparam logic signed [ACC_WIDTH-1:0] U_MAX =
    {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] S_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] S_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic [1:0]                   state_reg, state_next;
  logic signed [ACC_WIDTH-1:0]  acc_reg, acc_next;
  logic [CNT_WIDTH-1:0]         count_reg, count_next;
  logic [CNT_WIDTH-1:0]         len_reg, len_next;
  logic [3:0]                   shift_reg, shift_next;
  logic                         relu_reg, relu_next;
  logic [DATA_WIDTH-1:0]        data_reg, data_next;
  logic                         done_reg, done_next;

  logic                         psum_accept;
  logic                         last_accept;
  logic signed [ACC_WIDTH-1:0]  psum_ext;
  logic signed [ACC_WIDTH-1:0]  acc_sum;
  logic signed [ACC_WIDTH-1:0]  acc_shifted;
  logic [DATA_WIDTH-1:0]        result;

  assign o_psum_ready = (state_reg == ACCUM);
  assign o_data_valid = (state_reg == OUT);
  assign o_busy       = (state_reg != IDLE);
  assign o_data       = data_reg;
  assign o_done       = done_reg;

  assign psum_accept = o_psum_ready & i_psum_valid;
  assign last_accept = psum_accept && (count_reg == (len_reg - CNT_WIDTH'(1)));

  assign psum_ext    = {{(ACC_WIDTH-COLUMN_OUT_WIDTH){i_psum_column[COLUMN_OUT_WIDTH-1]}},
                        i_psum_column};
  assign acc_sum     = acc_reg + psum_ext;
  assign acc_shifted = acc_sum >>> shift_reg;

  // Saturate the shifted sum into the output range chosen at window start.
  always_comb begin
    result = acc_shifted[DATA_WIDTH-1:0];
    if (relu_reg) begin
      if (acc_shifted < 0) begin
        result = '0;
      end else if (acc_shifted > U_MAX) begin
        result = '1;
      end
    end else begin
      if (acc_shifted > S_MAX) begin
        result = S_MAX[DATA_WIDTH-1:0];
      end else if (acc_shifted < S_MIN) begin
        result = S_MIN[DATA_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    count_next = count_reg;
    len_next   = len_reg;
    shift_next = shift_reg;
    relu_next  = relu_reg;
    data_next  = data_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_start) begin
          state_next = ACCUM;
          acc_next   = '0;
          count_next = '0;
          len_next   = (i_len == '0) ? {1'b1, {LEN_WIDTH{1'b0}}} : {1'b0, i_len};
          shift_next = i_shift;
          relu_next  = i_relu;
        end
      end
      ACCUM: begin
        if (psum_accept) begin
          acc_next   = acc_sum;
          count_next = count_reg + CNT_WIDTH'(1);
          if (last_accept) begin
            state_next = OUT;
            data_next  = result;
          end
        end
      end
      OUT: begin
        if (i_data_ready) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      count_reg <= '0;
      len_reg   <= '0;
      shift_reg <= '0;
      relu_reg  <= 1'b0;
      data_reg  <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      count_reg <= count_next;
      len_reg   <= len_next;
      shift_reg <= shift_next;
      relu_reg  <= relu_next;
      data_reg  <= data_next;
      done_reg  <= done_next;
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Randomized and directed windows checked against a plain-arithmetic model of
// sum, arithmetic shift and clamp.
module tb_psum_accumulator;

  logic              clk;
  logic              i_rst_n;
  logic              i_start;
  logic [3:0]        i_len;
  logic [3:0]        i_shift;
  logic              i_relu;
  logic              i_psum_valid;
  logic signed [18:0] i_psum_column;
  logic              o_psum_ready;
  logic              o_data_valid;
  logic [7:0]        o_data;
  logic              i_data_ready;
  logic              o_busy;
  logic              o_done;

  int n_cmp = 0;
  int n_bad = 0;
  int psums[$];

  psum_accumulator dut (
    .i_clk         (clk),
    .i_rst_n       (i_rst_n),
    .i_start       (i_start),
    .i_len         (i_len),
    .i_shift       (i_shift),
    .i_relu        (i_relu),
    .i_psum_valid  (i_psum_valid),
    .i_psum_column (i_psum_column),
    .o_psum_ready  (o_psum_ready),
    .o_data_valid  (o_data_valid),
    .o_data        (o_data),
    .i_data_ready  (i_data_ready),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_result(input longint sum, input int shift, input bit relu);
    longint v;
    v = sum >>> shift;
    if (relu) begin
      if (v < 0)   return 8'd0;
      if (v > 255) return 8'd255;
    end else begin
      if (v > 127)  return 8'h7F;
      if (v < -128) return 8'h80;
    end
    return v[7:0];
  endfunction

  // Runs one window using the psums queue; hold = cycles of i_data_ready low in OUT.
  task automatic run_window(input int len_field, input int shift, input bit relu, input int hold);
    longint     sum;
    logic [7:0] exp_data;
    int         n;
    n   = (len_field == 0) ? 16 : len_field;
    sum = 0;
    for (int i = 0; i < n; i++) sum += psums[i];
    exp_data = ref_result(sum, shift, relu);

    @(negedge clk);
    i_start       = 1'b1;
    i_len         = 4'(len_field);
    i_shift       = 4'(shift);
    i_relu        = relu;
    i_psum_valid  = 1'b1;
    i_psum_column = 19'(int'($urandom_range(0, 524287)));
    @(negedge clk);
    i_start      = 1'b0;
    i_psum_valid = 1'b0;
    check("busy_after_start", o_busy, 1);
    check("valid_after_start", o_data_valid, 0);

    for (int k = 0; k < n; k++) begin
      while ($urandom_range(0, 3) == 0) begin
        i_psum_valid = 1'b0;
        @(negedge clk);
      end
      check("psum_ready", o_psum_ready, 1);
      check("no_early_valid", o_data_valid, 0);
      i_psum_valid  = 1'b1;
      i_psum_column = 19'(psums[k]);
      @(negedge clk);
    end
    i_psum_valid = 1'b0;
    check("data_valid", o_data_valid, 1);
    check("data", o_data, exp_data);
    check("ready_in_out", o_psum_ready, 0);

    for (int h = 0; h < hold; h++) begin
      i_data_ready  = 1'b0;
      i_start       = 1'($urandom_range(0, 1));
      i_len         = 4'($urandom_range(0, 15));
      i_shift       = 4'($urandom_range(0, 15));
      i_relu        = 1'($urandom_range(0, 1));
      i_psum_valid  = 1'b1;
      i_psum_column = 19'(int'($urandom_range(0, 524287)));
      @(negedge clk);
      check("hold_valid", o_data_valid, 1);
      check("hold_data", o_data, exp_data);
      check("hold_no_done", o_done, 0);
    end

    i_start      = 1'b0;
    i_psum_valid = 1'b0;
    i_data_ready = 1'b1;
    @(negedge clk);
    i_data_ready = 1'b0;
    check("done_pulse", o_done, 1);
    check("idle_busy", o_busy, 0);
    check("idle_valid", o_data_valid, 0);
    @(negedge clk);
    check("done_single", o_done, 0);
    psums.delete();
  endtask

  initial begin
    int lf;
    int nn;
    i_rst_n       = 1'b0;
    i_start       = 1'b0;
    i_len         = '0;
    i_shift       = '0;
    i_relu        = 1'b0;
    i_psum_valid  = 1'b0;
    i_psum_column = '0;
    i_data_ready  = 1'b0;
    #1;
    check("rst_busy", o_busy, 0);
    check("rst_ready", o_psum_ready, 0);
    check("rst_valid", o_data_valid, 0);
    check("rst_data", o_data, 0);
    check("rst_done", o_done, 0);
    repeat (2) @(negedge clk);
    i_rst_n = 1'b1;

    // Directed windows.
    psums = '{10, 20, 30};
    run_window(3, 0, 1, 0);
    psums = '{-100, -3};
    run_window(2, 2, 0, 1);
    psums = '{-5};
    run_window(1, 0, 1, 0);
    psums = '{1000};
    run_window(1, 0, 1, 0);
    psums = '{1000};
    run_window(1, 0, 0, 0);
    for (int i = 0; i < 16; i++) psums.push_back(196095);
    run_window(0, 15, 1, 0);
    for (int i = 0; i < 16; i++) psums.push_back(-262144);
    run_window(0, 15, 0, 0);
    psums = '{3, 4};
    run_window(2, 0, 0, 5);

    // Reset in the middle of a window discards it.
    @(negedge clk);
    i_start = 1'b1; i_len = 4'd4; i_shift = 4'd0; i_relu = 1'b0;
    @(negedge clk);
    i_start = 1'b0; i_psum_valid = 1'b1; i_psum_column = 19'sd11;
    @(negedge clk);
    i_psum_column = 19'sd22;
    @(negedge clk);
    i_psum_valid = 1'b0;
    #2 i_rst_n = 1'b0;
    #1;
    check("midrst_busy", o_busy, 0);
    check("midrst_ready", o_psum_ready, 0);
    check("midrst_valid", o_data_valid, 0);
    check("midrst_data", o_data, 0);
    check("midrst_done", o_done, 0);
    @(negedge clk);
    i_rst_n = 1'b1;
    i_psum_valid = 1'b1; i_psum_column = 19'sd5;
    repeat (3) begin
      @(negedge clk);
      check("postrst_valid", o_data_valid, 0);
      check("postrst_busy", o_busy, 0);
    end
    i_psum_valid = 1'b0;
    psums = '{7};
    run_window(1, 0, 0, 0);

    // Randomized windows.
    for (int w = 0; w < 40; w++) begin
      lf = int'($urandom_range(0, 15));
      nn = (lf == 0) ? 16 : lf;
      for (int i = 0; i < nn; i++) begin
        if ($urandom_range(0, 1) == 1)
          psums.push_back(int'($urandom_range(0, 524287)) - 262144);
        else
          psums.push_back(int'($urandom_range(0, 600)) - 300);
      end
      run_window(lf, int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
